iob_axi_burst_ram: RTL
======================

# iob_axi_burst_ram

AXI4 slave burst memory that sits directly downstream of the cache's AXI4 master back-end. It consumes the cache's line-fill read bursts and write-through/write-back write bursts and serves them from an internal single-port word-addressed RAM. It is used as the system-level backing store in simulation and small FPGA builds. It serves one transaction at a time, with round-robin arbitration between the read and write address channels.

## Interface
- AXI_ID_W, 1, ID width; rid/bid return the captured arid/awid.
- AXI_LEN_W, 8, burst length field width; a burst has len+1 beats.
- AXI_ADDR_W, 24, byte address width.
- AXI_DATA_W, 32, data width; NBYTES = AXI_DATA_W/8, NBYTES_W = log2(NBYTES).
- MEM_ADDR_W, 10, RAM depth is 2^MEM_ADDR_W words.
- clk_i  in  1  clock, rising edge.
- cke_i  in  1  clock enable; when low, all state freezes.
- arst_i  in  1  reset, asynchronous, active-high.
- axi_ar{addr,valid,id,len,size,burst,lock,cache,qos}_i  in  AXI_ADDR_W/1/AXI_ID_W/AXI_LEN_W/3/2/1/4/4  read address channel; lock, cache, qos and burst are ignored.
- axi_arready_o  out  1  read address accept.
- axi_r{data,resp,id,last,valid}_o  out  AXI_DATA_W/2/AXI_ID_W/1/1  read data channel.
- axi_rready_i  in  1  read data accept.
- axi_aw{addr,valid,id,len,size,burst,lock,cache,qos}_i  in  same widths as AR  write address channel; same ignored fields.
- axi_awready_o  out  1  write address accept.
- axi_w{data,strb,last,valid}_i  in  AXI_DATA_W/NBYTES/1/1  write data channel.
- axi_wready_o  out  1  write data accept.
- axi_b{resp,id,valid}_o  out  2/AXI_ID_W/1  write response channel.
- axi_bready_i  in  1  write response accept.

## Operation
- FSM states: IDLE, RD_FETCH, RD_BURST, WR_DATA, WR_RESP.
- IDLE, arbitration:
  - Only one of arvalid or awvalid is high: grant it.
  - Both are high: grant the type opposite to last_served.
  - last_served resets to READ, so the first contention goes to the write.
- Ready outputs (combinational):
  - axi_arready_o = IDLE & cke_i & grant_rd.
  - axi_awready_o = IDLE & cke_i & grant_wr.
- AR handshake:
  - Captures word index = araddr[MEM_ADDR_W+NBYTES_W-1:NBYTES_W], beat count = arlen, and arid.
  - Sets last_served = READ and moves to RD_FETCH.
- RD_FETCH: presents the RAM read address for one cycle, then moves to RD_BURST.
- RD_BURST:
  - rvalid=1, rdata=RAM[index], rresp=2'b00, rid=captured id, rlast=(beat==len).
  - Beats advance only on rvalid&rready. The next word is prefetched so that with rready held high one beat is issued per cycle.
  - The last beat handshake returns the FSM to IDLE.
- AW handshake: captures index, len and awid, sets last_served = WRITE, and moves to WR_DATA.
- WR_DATA:
  - wready=cke_i.
  - Each wvalid&wready beat writes RAM[index] bytewise under wstrb, then index increments.
  - The beat counter reaching len ends the burst and moves to WR_RESP.
  - If wlast differs from (beat==len) on any beat, an error flag is set. All data is still written.
- WR_RESP:
  - bvalid=1, bid=captured id, bresp = 2'b10 (SLVERR) if the error flag is set, else 2'b00.
  - bvalid&bready returns to IDLE and clears the error flag.
- Address arithmetic:
  - index increments by 1 per beat, modulo 2^MEM_ADDR_W (wrap-around, no error).
  - Byte-offset address bits are ignored. Every burst type is treated as INCR. arsize/awsize are assumed to equal NBYTES_W and are not checked.
- W beats are never accepted before their AW handshake (wready=0 outside WR_DATA).

## Timing
- Reset values:
  - All ready/valid outputs 0, rlast 0, rresp/bresp 2'b00, rdata 0, rid/bid 0.
  - State IDLE, last_served READ.
  - RAM contents are not reset.
- Read latency: AR handshake at edge N; first rvalid high in cycle N+2. Back-to-back beats follow with no bubbles while rready is high.
- rready low: rvalid, rdata, rid and rlast hold stable until accepted.
- Write: AW handshake at edge N; wready high from cycle N+1. bvalid is high in the cycle after the last W beat handshake.
- Minimum gap between transactions: one IDLE cycle after the final R or B handshake.
- cke_i low: state, counters and all registered outputs hold; ready outputs are forced low; no RAM write occurs.
- arst_i asserted mid-burst: immediate return to reset values. The partial burst is abandoned and words already written stay written.

## Test plan
- Preload words 0..3 with 0x11111111..0x44444444 via one AW len=3 burst at addr 0x0 -> bvalid with bresp=00 and bid=awid. Then an AR len=3 at 0x0 -> rvalid at N+2 and four beats 0x11111111..0x44444444 on consecutive cycles, rlast only on the 4th.
- Assert arvalid and awvalid together from reset -> write granted first. After its B handshake, the read is granted. On the next contention the write wins again, since last_served = READ.
- Write wstrb=4'b0101 data 0xAABBCCDD to a word holding 0x44444444 -> readback 0x44BB44DD.
- Read len=7 with rready toggling 1,0,1,0 -> rdata and rlast stable while rready=0, all 8 beats delivered in order.
- AW len=1 with wlast high on the first beat -> both beats written, bresp=2'b10. Next burst returns bresp=00.
- Write at word index 2^MEM_ADDR_W-1, len=1 -> second beat lands at index 0. Assert arst_i during beat 3 of a len=7 read -> rvalid=0 next cycle, FSM IDLE, arready responds to a new AR.

Source files
------------

// File: rtl/iob_axi_burst_ram_if.sv
// iob_axi_burst_ram_if: AXI4 bus bundle between a burst master and the burst RAM slave.
interface iob_axi_burst_ram_if #(
    parameter int ID_W   = 1,
    parameter int LEN_W  = 8,
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic [ID_W-1:0]     arid;
    logic [LEN_W-1:0]    arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arlock;
    logic [3:0]          arcache;
    logic [3:0]          arqos;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic [ID_W-1:0]     rid;
    logic                rlast;
    logic                rvalid;
    logic                rready;
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic [ID_W-1:0]     awid;
    logic [LEN_W-1:0]    awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic [3:0]          awcache;
    logic [3:0]          awqos;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic [ID_W-1:0]     bid;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arvalid, arid, arlen, arsize, arburst, arlock, arcache, arqos,
        input  arready,
        input  rdata, rresp, rid, rlast, rvalid,
        output rready,
        output awaddr, awvalid, awid, awlen, awsize, awburst, awlock, awcache, awqos,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bid, bvalid,
        output bready
    );

    modport slave (
        input  araddr, arvalid, arid, arlen, arsize, arburst, arlock, arcache, arqos,
        output arready,
        output rdata, rresp, rid, rlast, rvalid,
        input  rready,
        input  awaddr, awvalid, awid, awlen, awsize, awburst, awlock, awcache, awqos,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bid, bvalid,
        input  bready
    );
endinterface

// File: rtl/iob_axi_burst_ram.sv
// iob_axi_burst_ram: AXI4 slave serving one INCR burst at a time from a word-addressed RAM,
// with round-robin arbitration between the read and write address channels.
module iob_axi_burst_ram #(
    parameter int AXI_ID_W   = 1,
    parameter int AXI_LEN_W  = 8,
    parameter int AXI_ADDR_W = 24,
    parameter int AXI_DATA_W = 32,
    parameter int MEM_ADDR_W = 10
) (
    input logic clk_i,
    input logic cke_i,
    input logic arst_i,
    iob_axi_burst_ram_if.slave axi
);
    localparam int NBYTES   = AXI_DATA_W / 8;
    localparam int NBYTES_W = $clog2(NBYTES);

    typedef enum logic [2:0] {IDLE, RD_FETCH, RD_BURST, WR_DATA, WR_RESP} state_t;

    state_t                  state;
    logic                    last_wr;
    logic [MEM_ADDR_W-1:0]   idx;
    logic [AXI_LEN_W-1:0]    len;
    logic [AXI_LEN_W-1:0]    beat;
    logic [AXI_ID_W-1:0]     id;
    logic                    err;
    logic [AXI_DATA_W-1:0]   rdata;
    logic                    rvalid;
    logic                    rlast;
    logic                    bvalid;
    logic [1:0]              bresp;
    logic [AXI_DATA_W-1:0]   mem [2**MEM_ADDR_W];
    logic                    grant_rd;
    logic                    grant_wr;
    logic                    w_end;
    logic                    w_bad;
    logic                    unused;

    // On contention the channel that was not served last wins.
    assign grant_rd = axi.arvalid & (!axi.awvalid | last_wr);
    assign grant_wr = axi.awvalid & (!axi.arvalid | !last_wr);
    assign w_end    = beat == len;
    assign w_bad    = axi.wlast != w_end;

    assign axi.arready = state == IDLE & cke_i & grant_rd;
    assign axi.awready = state == IDLE & cke_i & grant_wr;
    assign axi.wready  = state == WR_DATA & cke_i;
    assign axi.rdata   = rdata;
    assign axi.rresp   = 2'b00;
    assign axi.rid     = id;
    assign axi.rlast   = rlast;
    assign axi.rvalid  = rvalid;
    assign axi.bresp   = bresp;
    assign axi.bid     = id;
    assign axi.bvalid  = bvalid;

    assign unused = ^{axi.araddr, axi.arsize, axi.arburst, axi.arlock, axi.arcache, axi.arqos,
                      axi.awaddr, axi.awsize, axi.awburst, axi.awlock, axi.awcache, axi.awqos};

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state   <= IDLE;
            last_wr <= 1'b0;
            idx     <= '0;
            len     <= '0;
            beat    <= '0;
            id      <= '0;
            err     <= 1'b0;
            rdata   <= '0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= 2'b00;
        end else if (cke_i) begin
            case (state)
                IDLE: begin
                    if (grant_rd) begin
                        idx     <= axi.araddr[MEM_ADDR_W+NBYTES_W-1:NBYTES_W];
                        len     <= axi.arlen;
                        id      <= axi.arid;
                        last_wr <= 1'b0;
                        state   <= RD_FETCH;
                    end else if (grant_wr) begin
                        idx     <= axi.awaddr[MEM_ADDR_W+NBYTES_W-1:NBYTES_W];
                        len     <= axi.awlen;
                        id      <= axi.awid;
                        beat    <= '0;
                        last_wr <= 1'b1;
                        state   <= WR_DATA;
                    end
                end
                RD_FETCH: begin
                    rdata  <= mem[idx];
                    idx    <= idx + MEM_ADDR_W'(1);
                    beat   <= '0;
                    rlast  <= len == '0;
                    rvalid <= 1'b1;
                    state  <= RD_BURST;
                end
                RD_BURST: begin
                    if (axi.rready) begin
                        if (rlast) begin
                            rvalid <= 1'b0;
                            rlast  <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            // idx already points one word ahead, so the next beat is ready now.
                            rdata <= mem[idx];
                            idx   <= idx + MEM_ADDR_W'(1);
                            beat  <= beat + AXI_LEN_W'(1);
                            rlast <= beat + AXI_LEN_W'(1) == len;
                        end
                    end
                end
                WR_DATA: begin
                    if (axi.wvalid) begin
                        idx  <= idx + MEM_ADDR_W'(1);
                        beat <= beat + AXI_LEN_W'(1);
                        if (w_bad) err <= 1'b1;
                        if (w_end) begin
                            bvalid <= 1'b1;
                            bresp  <= (err | w_bad) ? 2'b10 : 2'b00;
                            state  <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (axi.bready) begin
                        bvalid <= 1'b0;
                        bresp  <= 2'b00;
                        err    <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (axi.wready & axi.wvalid)
            for (int b = 0; b < NBYTES; b++)
                if (axi.wstrb[b]) mem[idx][8*b +: 8] <= axi.wdata[8*b +: 8];
    end
endmodule
